// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS writeback stage.
//   load_op_t     : load opcode encodings carried on req_load_op
//   wb_state_t    : writeback control states
//   MIPS_REG_ZERO : hard-wired zero register index (never written)
package mips_wb_pkg;

    typedef enum logic [2:0] {
        OpLb   = 3'd0,
        OpLbu  = 3'd1,
        OpLh   = 3'd2,
        OpLhu  = 3'd3,
        OpLw   = 3'd4,
        OpLwl  = 3'd5,
        OpLwr  = 3'd6,
        OpRsvd = 3'd7   // decoded as a plain word load
    } load_op_t;

    typedef enum logic {
        StIdle     = 1'b0,
        StWaitLoad = 1'b1
    } wb_state_t;

    localparam logic [4:0] MIPS_REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_load_aligner.sv
// Combinational load data aligner: selects the addressed byte/halfword from a
// little-endian memory word and sign/zero-extends it, or merges it with the old
// rt value for LWL/LWR.
// Build option: WB_UNALIGNED_LOAD_EN enables the LWL/LWR merge; without it ops
// 5 and 6 return the full word and rt_old is ignored.
// Ports:
//   op       in  3   load opcode (load_op_t encoding)
//   offset   in  2   effective address bits [1:0]
//   readdata in  32  little-endian memory word
//   rt_old   in  32  current rt value (LWL/LWR only)
//   result   out 32  value to write back
module mips_load_aligner
    import mips_wb_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    load_op_t    op_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op_e = load_op_t'(op);

`ifdef WB_UNALIGNED_LOAD_EN
    logic [31:0] merge_left;
    logic [31:0] merge_right;

    // LWL keeps the low bytes of rt below the loaded bytes; LWR keeps the high bytes.
    always_comb begin
        merge_left  = readdata;
        merge_right = readdata;
        case (offset)
            2'd0: begin
                merge_left  = {readdata[7:0], rt_old[23:0]};
                merge_right = readdata;
            end
            2'd1: begin
                merge_left  = {readdata[15:0], rt_old[15:0]};
                merge_right = {rt_old[31:24], readdata[31:8]};
            end
            2'd2: begin
                merge_left  = {readdata[23:0], rt_old[7:0]};
                merge_right = {rt_old[31:16], readdata[31:16]};
            end
            default: begin
                merge_left  = readdata;
                merge_right = {rt_old[31:8], readdata[31:24]};
            end
        endcase
    end
`else
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old;
`endif

    always_comb begin
        byte_sel = readdata[7:0];
        case (offset)
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        // Halfword selection ignores offset[0].
        half_sel = offset[1] ? readdata[31:16] : readdata[15:0];

        result = readdata;
        case (op_e)
            OpLb:    result = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   result = {24'd0, byte_sel};
            OpLh:    result = {{16{half_sel[15]}}, half_sel};
            OpLhu:   result = {16'd0, half_sel};
`ifdef WB_UNALIGNED_LOAD_EN
            OpLwl:   result = merge_left;
            OpLwr:   result = merge_right;
`endif
            default: result = readdata;
        endcase
    end

endmodule

// File: rtl/mips_writeback_stage.sv
// MIPS writeback stage: drives the register file write port. Non-load results
// are written one cycle after the handshake; loads wait for memory data, which
// is aligned/extended before the write. A load that sees no data for
// LOAD_TIMEOUT cycles is abandoned and raises a sticky load_timeout flag.
// Build option: WB_UNALIGNED_LOAD_EN enables LWL/LWR merging with req_rt_old.
// Ports:
//   clk, reset (sync, active low)
//   req_valid/req_ready          retiring-instruction handshake (ready only in IDLE)
//   req_is_load, req_load_op, req_byte_offset, req_dest, req_alu_result, req_rt_old
//   mem_readdatavalid, mem_readdata   load data return
//   write_enable, write_register, write_data   register file write port
//   load_pending                 high while waiting for load data
//   load_timeout                 sticky, cleared only by reset
module mips_writeback_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic [2:0]  req_load_op,
    input  logic [1:0]  req_byte_offset,
    input  logic [4:0]  req_dest,
    input  logic [31:0] req_alu_result,
    input  logic [31:0] req_rt_old,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    output logic        write_enable,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    output logic        load_pending,
    output logic        load_timeout
);

    localparam int unsigned CntW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CntW-1:0] LimitCnt = CntW'(LOAD_TIMEOUT);

    wb_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  dest_q, dest_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pending_q, pending_d;
    logic        timeout_q, timeout_d;
    logic [31:0] rt_align;
    logic [31:0] aligned;

`ifdef WB_UNALIGNED_LOAD_EN
    logic [31:0] rt_q, rt_d;
    assign rt_align = rt_q;
`else
    logic unused_rt_old;
    assign unused_rt_old = ^req_rt_old;
    assign rt_align = 32'd0;
`endif

    mips_load_aligner u_aligner (
        .op       (op_q),
        .offset   (off_q),
        .readdata (mem_readdata),
        .rt_old   (rt_align),
        .result   (aligned)
    );

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        off_d     = off_q;
        dest_d    = dest_q;
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        timeout_d = timeout_q;
`ifdef WB_UNALIGNED_LOAD_EN
        rt_d      = rt_q;
`endif
        case (state_q)
            StIdle: begin
                // mem_readdatavalid is deliberately ignored here.
                if (req_valid) begin
                    if (req_is_load) begin
                        op_d    = req_load_op;
                        off_d   = req_byte_offset;
                        dest_d  = req_dest;
`ifdef WB_UNALIGNED_LOAD_EN
                        rt_d    = req_rt_old;
`endif
                        cnt_d   = '0;
                        state_d = StWaitLoad;
                    end else begin
                        we_d    = (req_dest != MIPS_REG_ZERO);
                        wreg_d  = req_dest;
                        wdata_d = req_alu_result;
                    end
                end
            end
            StWaitLoad: begin
                // Data beats a timeout that expires in the same cycle.
                if (mem_readdatavalid) begin
                    we_d    = (dest_q != MIPS_REG_ZERO);
                    wreg_d  = dest_q;
                    wdata_d = aligned;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if ((LOAD_TIMEOUT != 0) && (cnt_inc == LimitCnt)) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        pending_d = (state_d == StWaitLoad);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= 3'd0;
            off_q     <= 2'd0;
            dest_q    <= 5'd0;
            we_q      <= 1'b0;
            wreg_q    <= 5'd0;
            wdata_q   <= 32'd0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef WB_UNALIGNED_LOAD_EN
            rt_q      <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            off_q     <= off_d;
            dest_q    <= dest_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
`ifdef WB_UNALIGNED_LOAD_EN
            rt_q      <= rt_d;
`endif
        end
    end

    assign req_ready      = (state_q == StIdle);
    assign write_enable   = we_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;
    assign load_pending   = pending_q;
    assign load_timeout   = timeout_q;

endmodule

// File: tb/tb_mips_writeback_stage.sv
module tb_mips_writeback_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic [2:0]  req_load_op;
    logic [1:0]  req_byte_offset;
    logic [4:0]  req_dest;
    logic [31:0] req_alu_result;
    logic [31:0] req_rt_old;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic        write_enable;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        load_pending;
    logic        load_timeout;

    int compared   = 0;
    int mismatched = 0;
    logic exp_to   = 1'b0;  // sticky timeout flag as the model sees it

    mips_writeback_stage #(
        .LOAD_TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_is_load       (req_is_load),
        .req_load_op       (req_load_op),
        .req_byte_offset   (req_byte_offset),
        .req_dest          (req_dest),
        .req_alu_result    (req_alu_result),
        .req_rt_old        (req_rt_old),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .write_enable      (write_enable),
        .write_register    (write_register),
        .write_data        (write_data),
        .load_pending      (load_pending),
        .load_timeout      (load_timeout)
    );

    always #5 clk = ~clk;

    // Reference load result, computed directly from the architectural rules.
    function automatic logic [31:0] ref_align(input int op, input int k,
                                              input logic [31:0] rd, input logic [31:0] rt);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * k)) & 32'hFF;
        h = (rd >> (16 * (k / 2))) & 32'hFFFF;
        case (op)
            0: return (b >= 32'd128) ? b - 32'd256 : b;
            1: return b;
            2: return (h >= 32'd32768) ? h - 32'd65536 : h;
            3: return h;
`ifdef WB_UNALIGNED_LOAD_EN
            5: return (rd << (8 * (3 - k))) | (rt & ((32'd1 << (8 * (3 - k))) - 32'd1));
            6: return (rd >> (8 * k)) | (rt & ~(32'hFFFFFFFF >> (8 * k)));
`endif
            default: return rd;
        endcase
    endfunction

    // One non-load transaction starting and ending on a falling edge.
    task automatic do_alu(input logic [4:0] dest, input logic [31:0] data, input string name);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready: got %b expected 1", name, req_ready);
        end
        req_valid      = 1'b1;
        req_is_load    = 1'b0;
        req_dest       = dest;
        req_alu_result = data;
        req_load_op    = 3'($urandom_range(0, 7));
        @(negedge clk);
        req_valid = 1'b0;
        compared++;
        if (dest == 5'd0) begin
            if (write_enable !== 1'b0) begin
                mismatched++;
                $display("FAIL %s r0 write: got we=%b expected 0", name, write_enable);
            end
        end else if ({write_enable, write_register, write_data} !== {1'b1, dest, data}) begin
            mismatched++;
            $display("FAIL %s write: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h",
                     name, write_enable, write_register, write_data, dest, data);
        end
    endtask

    // One load transaction: delay = data-less wait cycles before data is returned.
    task automatic do_load(input logic [2:0] op, input logic [1:0] off, input logic [4:0] dest,
                           input logic [31:0] rt, input logic [31:0] rd, input int delay,
                           input logic [31:0] exp, input string name);
        bit to;
        int n;
        to = (delay >= TIMEOUT);
        n  = to ? TIMEOUT : delay + 1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready: got %b expected 1", name, req_ready);
        end
        req_valid       = 1'b1;
        req_is_load     = 1'b1;
        req_load_op     = op;
        req_byte_offset = off;
        req_dest        = dest;
        req_rt_old      = rt;
        req_alu_result  = $urandom();
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            compared++;
            if ({load_pending, req_ready, write_enable} !== 3'b100) begin
                mismatched++;
                $display("FAIL %s wait%0d: got pend/ready/we=%b%b%b expected 100",
                         name, k, load_pending, req_ready, write_enable);
            end
            mem_readdatavalid = (k == delay);
            mem_readdata      = (k == delay) ? rd : $urandom();
            @(negedge clk);
        end
        mem_readdatavalid = 1'b0;
        if (to) exp_to = 1'b1;
        compared++;
        if ({load_pending, req_ready, load_timeout} !== {2'b01, exp_to}) begin
            mismatched++;
            $display("FAIL %s end: got pend/ready/to=%b%b%b expected 01%b",
                     name, load_pending, req_ready, load_timeout, exp_to);
        end
        compared++;
        if (to || dest == 5'd0) begin
            if (write_enable !== 1'b0) begin
                mismatched++;
                $display("FAIL %s no-write: got we=%b expected 0", name, write_enable);
            end
        end else if ({write_enable, write_register, write_data} !== {1'b1, dest, exp}) begin
            mismatched++;
            $display("FAIL %s write: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h",
                     name, write_enable, write_register, write_data, dest, exp);
        end
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        req_valid         = 1'b0;
        req_is_load       = 1'b0;
        req_load_op       = 3'd0;
        req_byte_offset   = 2'd0;
        req_dest          = 5'd0;
        req_alu_result    = 32'd0;
        req_rt_old        = 32'd0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        compared++;
        if ({req_ready, write_enable, write_register, write_data, load_pending, load_timeout}
            !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset: got ready=%b we=%b reg=%0d data=%h pend=%b to=%b expected 1 0 0 0 0 0",
                     req_ready, write_enable, write_register, write_data, load_pending, load_timeout);
        end
    endtask

    task automatic test_alu();
        do_alu(5'd9, 32'hDEADBEEF, "alu_deadbeef");
        @(negedge clk);
        compared++;
        if (write_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL alu_pulse: got we=%b expected 0", write_enable);
        end
    endtask

    task automatic test_lb_lbu_lh();
        // Data on the last wait cycle also coincides with the timeout limit.
        do_load(3'd0, 2'd2, 5'd3, 32'h0, 32'h128034FF, 3, 32'hFFFFFF80, "lb");
        do_load(3'd1, 2'd2, 5'd4, 32'h0, 32'h128034FF, 3, 32'h00000080, "lbu");
        do_load(3'd2, 2'd2, 5'd5, 32'h0, 32'h128034FF, 1, 32'h00001280, "lh_off2");
        do_load(3'd2, 2'd3, 5'd6, 32'h0, 32'h128034FF, 0, 32'h00001280, "lh_off3");
    endtask

    task automatic test_lwl_lwr();
`ifdef WB_UNALIGNED_LOAD_EN
        do_load(3'd5, 2'd1, 5'd7, 32'h11223344, 32'hAABBCCDD, 2, 32'hCCDD3344, "lwl");
        do_load(3'd6, 2'd1, 5'd8, 32'h11223344, 32'hAABBCCDD, 2, 32'h11AABBCC, "lwr");
`else
        do_load(3'd5, 2'd1, 5'd7, 32'h11223344, 32'hAABBCCDD, 2, 32'hAABBCCDD, "lwl");
        do_load(3'd6, 2'd1, 5'd8, 32'h11223344, 32'hAABBCCDD, 2, 32'hAABBCCDD, "lwr");
`endif
    endtask

    task automatic test_reg_zero_spurious();
        do_alu(5'd0, 32'h12345678, "alu_r0");
        do_load(3'd4, 2'd0, 5'd0, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, "load_r0");
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'h55AA55AA;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        compared++;
        if ({write_enable, load_pending, req_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL spurious: got we/pend/ready=%b%b%b expected 001",
                     write_enable, load_pending, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            do_alu(5'($urandom_range(1, 31)), $urandom(), "b2b_alu");
        end
    endtask

    task automatic test_timeout();
        do_load(3'd4, 2'd0, 5'd10, 32'h0, 32'h0, 10, 32'h0, "timeout");
        // A following load still completes normally with the flag held.
        do_load(3'd4, 2'd0, 5'd11, 32'h0, 32'h01020304, 0, 32'h01020304, "after_to");
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_alu(5'($urandom_range(0, 31)), $urandom(), "rnd_alu");
            end else begin
                logic [2:0]  op;
                logic [1:0]  off;
                logic [31:0] rd;
                logic [31:0] rt;
                op  = 3'($urandom_range(0, 7));
                off = 2'($urandom_range(0, 3));
                rd  = $urandom();
                rt  = $urandom();
                do_load(op, off, 5'($urandom_range(0, 31)), rt, rd, $urandom_range(0, 5),
                        ref_align(int'(op), int'(off), rd, rt), "rnd_load");
            end
        end
    endtask

    task automatic test_reset_mid_load();
        req_valid       = 1'b1;
        req_is_load     = 1'b1;
        req_load_op     = 3'd4;
        req_byte_offset = 2'd0;
        req_dest        = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        exp_to = 1'b0;
        compared++;
        if ({req_ready, write_enable, write_register, write_data, load_pending, load_timeout}
            !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset: got ready=%b we=%b reg=%0d data=%h pend=%b to=%b expected 1 0 0 0 0 0",
                     req_ready, write_enable, write_register, write_data, load_pending, load_timeout);
        end
        mem_readdatavalid = 1'b1;
        mem_readdata      = 32'hFEEDFACE;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        compared++;
        if ({write_enable, load_pending, req_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL mid_reset_late_data: got we/pend/ready=%b%b%b expected 001",
                     write_enable, load_pending, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_lbu_lh();
        test_lwl_lwr();
        test_reg_zero_spurious();
        test_back_to_back();
        test_timeout();
        test_random_mix();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
